// File: rtl/csr_access_ctrl_pkg.sv
// Shared constants for the CSR access sequencer: CSR addresses, ROB op
// encodings, exception codes and sequencer state encodings.
package csr_access_ctrl_pkg;

    localparam logic [13:0] CSR_CRMD      = 14'h000;
    localparam logic [13:0] CSR_PRMD      = 14'h001;
    localparam logic [13:0] CSR_ESTAT     = 14'h005;
    localparam logic [13:0] CSR_ERA       = 14'h006;
    localparam logic [13:0] CSR_BADV      = 14'h007;
    localparam logic [13:0] CSR_EENTRY    = 14'h00c;
    localparam logic [13:0] CSR_TLBRENTRY = 14'h088;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_XCHG = 2'b10;

    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_ROB     = 4'd1;
    localparam logic [3:0] S_E_PRMD  = 4'd2;
    localparam logic [3:0] S_E_CRMD  = 4'd3;
    localparam logic [3:0] S_E_ERA   = 4'd4;
    localparam logic [3:0] S_E_ESTAT = 4'd5;
    localparam logic [3:0] S_E_BADV  = 4'd6;
    localparam logic [3:0] S_E_REDIR = 4'd7;
    localparam logic [3:0] S_R_PRMD  = 4'd8;
    localparam logic [3:0] S_R_CRMD  = 4'd9;
    localparam logic [3:0] S_R_REDIR = 4'd10;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esubcode;
        logic       badv_valid;
    } exc_info_t;

endpackage

// File: rtl/csr_access_ctrl_arb.sv
// Fixed-priority grant (Exc > Ertn > Rob) for the CSR port; grants only
// while the sequencer is idle.
module csr_ctrl_arb (
    input  logic idle_i,
    input  logic exc_valid_i,
    input  logic ertn_valid_i,
    input  logic rob_valid_i,
    output logic exc_grant_o,
    output logic ertn_grant_o,
    output logic rob_grant_o
);

    assign exc_grant_o  = idle_i & exc_valid_i;
    assign ertn_grant_o = idle_i & ~exc_valid_i & ertn_valid_i;
    assign rob_grant_o  = idle_i & ~exc_valid_i & ~ertn_valid_i & rob_valid_i;

endmodule

// File: rtl/csr_access_ctrl.sv
// Serialises ROB CSR ops, exception entry and ertn onto the single CSR port,
// running the multi-step CSR update sequences and emitting the PC redirect.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
#(
    parameter int CSR_AW = 14,
    parameter int DW     = 32
) (
    input  logic              Clk,
    input  logic              Rest,
    input  logic              RobCsrValid,
    output logic              RobCsrReady,
    input  logic [1:0]        RobCsrOp,
    input  logic [CSR_AW-1:0] RobCsrAddr,
    input  logic [DW-1:0]     RobCsrWData,
    input  logic [DW-1:0]     RobCsrMask,
    output logic              RobCsrRespValid,
    output logic [DW-1:0]     RobCsrRData,
    input  logic              ExcValid,
    output logic              ExcReady,
    input  logic [5:0]        ExcEcode,
    input  logic [8:0]        ExcEsubcode,
    input  logic [DW-1:0]     ExcPc,
    input  logic [DW-1:0]     ExcBadv,
    input  logic              ExcBadvValid,
    input  logic              ErtnValid,
    output logic              ErtnReady,
    output logic [CSR_AW-1:0] CsrRAddr,
    input  logic [DW-1:0]     CsrRData,
    output logic              CsrWAble,
    output logic [CSR_AW-1:0] CsrWAddr,
    output logic [DW-1:0]     CsrWData,
    output logic              RedirectValid,
    output logic [DW-1:0]     RedirectPc,
    output logic              Busy
);

    logic [3:0]        state_q, state_d;
    logic [1:0]        op_q;
    logic [CSR_AW-1:0] addr_q;
    logic [DW-1:0]     wdata_q, mask_q, pc_q, badv_q;
    logic [DW-1:0]     scratch_q, scratch_d;
    exc_info_t         exc_q;
    logic              idle, grant_exc, grant_ertn, grant_rob;

    // Gating with Rest keeps every Ready low while reset is held.
    assign idle = (state_q == S_IDLE) & Rest;
    assign Busy = (state_q != S_IDLE);

    csr_ctrl_arb u_arb (
        .idle_i       (idle),
        .exc_valid_i  (ExcValid),
        .ertn_valid_i (ErtnValid),
        .rob_valid_i  (RobCsrValid),
        .exc_grant_o  (grant_exc),
        .ertn_grant_o (grant_ertn),
        .rob_grant_o  (grant_rob)
    );

    assign ExcReady    = grant_exc;
    assign ErtnReady   = grant_ertn;
    assign RobCsrReady = grant_rob;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_exc)       state_d = S_E_PRMD;
                else if (grant_ertn) state_d = S_R_PRMD;
                else if (grant_rob)  state_d = S_ROB;
            end
            S_ROB:     state_d = S_IDLE;
            S_E_PRMD:  state_d = S_E_CRMD;
            S_E_CRMD:  state_d = S_E_ERA;
            S_E_ERA:   state_d = S_E_ESTAT;
            S_E_ESTAT: state_d = exc_q.badv_valid ? S_E_BADV : S_E_REDIR;
            S_E_BADV:  state_d = S_E_REDIR;
            S_E_REDIR: state_d = S_IDLE;
            S_R_PRMD:  state_d = S_R_CRMD;
            S_R_CRMD:  state_d = S_R_REDIR;
            S_R_REDIR: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        CsrRAddr        = '0;
        CsrWAble        = 1'b0;
        CsrWAddr        = '0;
        CsrWData        = '0;
        RobCsrRespValid = 1'b0;
        RobCsrRData     = '0;
        RedirectValid   = 1'b0;
        RedirectPc      = '0;
        scratch_d       = scratch_q;
        case (state_q)
            S_ROB: begin
                CsrRAddr        = addr_q;
                RobCsrRespValid = 1'b1;
                RobCsrRData     = CsrRData;
                CsrWAddr        = addr_q;
                if (op_q == OP_WR) begin
                    CsrWAble = 1'b1;
                    CsrWData = wdata_q;
                end else if (op_q == OP_XCHG) begin
                    CsrWAble = 1'b1;
                    CsrWData = (CsrRData & ~mask_q) | (wdata_q & mask_q);
                end
            end
            S_E_PRMD: begin
                CsrRAddr  = CSR_CRMD;
                CsrWAble  = 1'b1;
                CsrWAddr  = CSR_PRMD;
                CsrWData  = {{(DW-3){1'b0}}, CsrRData[2:0]};
                scratch_d = CsrRData;
            end
            S_E_CRMD: begin
                CsrWAble = 1'b1;
                CsrWAddr = CSR_CRMD;
                CsrWData = {scratch_q[DW-1:3], 3'b000};
            end
            S_E_ERA: begin
                CsrWAble = 1'b1;
                CsrWAddr = CSR_ERA;
                CsrWData = pc_q;
            end
            S_E_ESTAT: begin
                CsrRAddr = CSR_ESTAT;
                CsrWAble = 1'b1;
                CsrWAddr = CSR_ESTAT;
                CsrWData = {CsrRData[31], exc_q.esubcode, exc_q.ecode, CsrRData[15:0]};
            end
            S_E_BADV: begin
                CsrWAble = 1'b1;
                CsrWAddr = CSR_BADV;
                CsrWData = badv_q;
            end
            S_E_REDIR: begin
                CsrRAddr      = (exc_q.ecode == ECODE_TLBR) ? CSR_TLBRENTRY : CSR_EENTRY;
                RedirectValid = 1'b1;
                RedirectPc    = CsrRData;
            end
            S_R_PRMD: begin
                CsrRAddr  = CSR_PRMD;
                scratch_d = CsrRData;
            end
            S_R_CRMD: begin
                CsrRAddr = CSR_CRMD;
                CsrWAble = 1'b1;
                CsrWAddr = CSR_CRMD;
                CsrWData = {CsrRData[DW-1:3], scratch_q[2:0]};
            end
            S_R_REDIR: begin
                CsrRAddr      = CSR_ERA;
                RedirectValid = 1'b1;
                RedirectPc    = CsrRData;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            state_q   <= S_IDLE;
            scratch_q <= '0;
            op_q      <= OP_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            pc_q      <= '0;
            badv_q    <= '0;
            exc_q     <= '0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            if (grant_rob) begin
                op_q    <= RobCsrOp;
                addr_q  <= RobCsrAddr;
                wdata_q <= RobCsrWData;
                mask_q  <= RobCsrMask;
            end
            if (grant_exc) begin
                exc_q  <= '{ecode: ExcEcode, esubcode: ExcEsubcode, badv_valid: ExcBadvValid};
                pc_q   <= ExcPc;
                badv_q <= ExcBadv;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: a CSR file model on the port, and a
// reference model that predicts each request's per-cycle writes and redirect.
module tb_csr_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rest = 1'b0;
    logic        RobCsrValid, RobCsrReady;
    logic [1:0]  RobCsrOp;
    logic [13:0] RobCsrAddr;
    logic [31:0] RobCsrWData, RobCsrMask;
    logic        RobCsrRespValid;
    logic [31:0] RobCsrRData;
    logic        ExcValid, ExcReady;
    logic [5:0]  ExcEcode;
    logic [8:0]  ExcEsubcode;
    logic [31:0] ExcPc, ExcBadv;
    logic        ExcBadvValid;
    logic        ErtnValid, ErtnReady;
    logic [13:0] CsrRAddr;
    logic [31:0] CsrRData;
    logic        CsrWAble;
    logic [13:0] CsrWAddr;
    logic [31:0] CsrWData;
    logic        RedirectValid;
    logic [31:0] RedirectPc;
    logic        Busy;

    csr_access_ctrl dut (
        .Clk(Clk), .Rest(Rest),
        .RobCsrValid(RobCsrValid), .RobCsrReady(RobCsrReady), .RobCsrOp(RobCsrOp),
        .RobCsrAddr(RobCsrAddr), .RobCsrWData(RobCsrWData), .RobCsrMask(RobCsrMask),
        .RobCsrRespValid(RobCsrRespValid), .RobCsrRData(RobCsrRData),
        .ExcValid(ExcValid), .ExcReady(ExcReady), .ExcEcode(ExcEcode),
        .ExcEsubcode(ExcEsubcode), .ExcPc(ExcPc), .ExcBadv(ExcBadv),
        .ExcBadvValid(ExcBadvValid), .ErtnValid(ErtnValid), .ErtnReady(ErtnReady),
        .CsrRAddr(CsrRAddr), .CsrRData(CsrRData), .CsrWAble(CsrWAble),
        .CsrWAddr(CsrWAddr), .CsrWData(CsrWData), .RedirectValid(RedirectValid),
        .RedirectPc(RedirectPc), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // CSR file on the port: combinational read, write at the clock edge.
    logic [31:0] mem   [0:16383];
    logic [31:0] model [0:16383];
    logic        poke_en = 1'b0;
    logic [13:0] poke_addr = '0;
    logic [31:0] poke_data = '0;

    assign CsrRData = mem[CsrRAddr];

    always @(posedge Clk) begin
        if (CsrWAble)     mem[CsrWAddr]  <= CsrWData;
        else if (poke_en) mem[poke_addr] <= poke_data;
    end

    int tests = 0;
    int fails = 0;

    // Expected per-cycle behaviour of one accepted request, offsets 1..6.
    bit          e_we   [1:6];
    logic [13:0] e_wa   [1:6];
    logic [31:0] e_wd   [1:6];
    bit          e_rv   [1:6];
    logic [31:0] e_rpc  [1:6];
    bit          e_resp [1:6];
    logic [31:0] e_rd   [1:6];
    int          e_len;

    localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ESTAT = 14'h5, A_ERA = 14'h6;
    localparam logic [13:0] A_BADV = 14'h7, A_EENTRY = 14'hc, A_TLBR = 14'h88;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 1; i <= 6; i++) begin
            e_we[i] = 0; e_wa[i] = '0; e_wd[i] = '0; e_rv[i] = 0;
            e_rpc[i] = '0; e_resp[i] = 0; e_rd[i] = '0;
        end
    endtask

    task automatic add_write(input int off, input logic [13:0] a, input logic [31:0] d);
        e_we[off] = 1; e_wa[off] = a; e_wd[off] = d;
    endtask

    task automatic prep_rob();
        logic [31:0] old;
        clear_exp();
        old = model[RobCsrAddr];
        e_len = 1; e_resp[1] = 1; e_rd[1] = old;
        if (RobCsrOp == 2'b01) add_write(1, RobCsrAddr, RobCsrWData);
        else if (RobCsrOp == 2'b10)
            add_write(1, RobCsrAddr, (old & ~RobCsrMask) | (RobCsrWData & RobCsrMask));
    endtask

    task automatic prep_exc();
        logic [31:0] crmd, estat, target;
        clear_exp();
        crmd   = model[A_CRMD];
        estat  = model[A_ESTAT];
        target = (ExcEcode == 6'h3F) ? model[A_TLBR] : model[A_EENTRY];
        add_write(1, A_PRMD, crmd % 8);
        add_write(2, A_CRMD, crmd - (crmd % 8));
        add_write(3, A_ERA, ExcPc);
        add_write(4, A_ESTAT, {estat[31], ExcEsubcode, ExcEcode, estat[15:0]});
        if (ExcBadvValid) add_write(5, A_BADV, ExcBadv);
        e_len = ExcBadvValid ? 6 : 5;
        e_rv[e_len] = 1; e_rpc[e_len] = target;
    endtask

    task automatic prep_ertn();
        logic [31:0] prmd, crmd;
        clear_exp();
        prmd = model[A_PRMD];
        crmd = model[A_CRMD];
        add_write(2, A_CRMD, crmd - (crmd % 8) + (prmd % 8));
        e_len = 3; e_rv[3] = 1; e_rpc[3] = model[A_ERA];
    endtask

    task automatic scramble();
        RobCsrOp = 2'($urandom); RobCsrAddr = 14'($urandom);
        RobCsrWData = $urandom; RobCsrMask = $urandom;
        ExcEcode = 6'($urandom); ExcEsubcode = 9'($urandom);
        ExcPc = $urandom; ExcBadv = $urandom; ExcBadvValid = 1'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".flags"}, 32'({RobCsrReady, ExcReady, ErtnReady, RobCsrRespValid,
                                    CsrWAble, RedirectValid, Busy}), 32'h0);
        check({tag, ".raddr"}, 32'(CsrRAddr), 32'h0);
        check({tag, ".waddr"}, 32'(CsrWAddr), 32'h0);
        check({tag, ".wdata"}, CsrWData, 32'h0);
        check({tag, ".rdata"}, RobCsrRData, 32'h0);
        check({tag, ".rpc"}, RedirectPc, 32'h0);
    endtask

    // Walks the cycles after acceptance; which: 0 exc, 1 ertn, 2 rob.
    // abort_at > 0 asserts reset at that cycle instead of checking it.
    task automatic observe(input int which, input bit scr, input int abort_at);
        for (int off = 1; off <= e_len; off++) begin
            @(negedge Clk);
            if (off == 1) begin
                if (which == 0) ExcValid = 1'b0;
                else if (which == 1) ErtnValid = 1'b0;
                else RobCsrValid = 1'b0;
                if (scr) scramble();
            end
            if (off == abort_at) begin
                Rest = 1'b0;
                #1;
                check_all_zero("abort");
                return;
            end
            check($sformatf("busy@%0d", off), 32'(Busy), 32'h1);
            check($sformatf("ready@%0d", off), 32'({ExcReady, ErtnReady, RobCsrReady}), 32'h0);
            check($sformatf("we@%0d", off), 32'(CsrWAble), 32'(e_we[off]));
            if (e_we[off]) check($sformatf("waddr@%0d", off), 32'(CsrWAddr), 32'(e_wa[off]));
            check($sformatf("wdata@%0d", off), CsrWData, e_we[off] ? e_wd[off] : 32'h0);
            check($sformatf("redir_v@%0d", off), 32'(RedirectValid), 32'(e_rv[off]));
            check($sformatf("redir_pc@%0d", off), RedirectPc, e_rv[off] ? e_rpc[off] : 32'h0);
            check($sformatf("resp_v@%0d", off), 32'(RobCsrRespValid), 32'(e_resp[off]));
            check($sformatf("resp_data@%0d", off), RobCsrRData, e_resp[off] ? e_rd[off] : 32'h0);
            if (e_we[off]) model[e_wa[off]] = e_wd[off];
        end
    endtask

    task automatic check_idle();
        @(negedge Clk);
        check("idle.busy", 32'(Busy), 32'h0);
        check("idle.strobes", 32'({CsrWAble, RedirectValid, RobCsrRespValid}), 32'h0);
        check("idle.data", CsrWData | RedirectPc | RobCsrRData, 32'h0);
    endtask

    task automatic issue(input int which, input bit scr);
        @(negedge Clk);
        check("pre.busy", 32'(Busy), 32'h0);
        if (which == 0) ExcValid = 1'b1;
        else if (which == 1) ErtnValid = 1'b1;
        else RobCsrValid = 1'b1;
        #1;
        if (which == 0) begin check("exc_ready", 32'(ExcReady), 32'h1); prep_exc(); end
        else if (which == 1) begin check("ertn_ready", 32'(ErtnReady), 32'h1); prep_ertn(); end
        else begin check("rob_ready", 32'(RobCsrReady), 32'h1); prep_rob(); end
        observe(which, scr, 0);
        check_idle();
    endtask

    // Call at a falling edge; leaves the bench at the next falling edge.
    task automatic poke(input logic [13:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        model[a] = d;
        @(negedge Clk);
        poke_en = 1'b0;
    endtask

    task automatic check_mem(input logic [13:0] a);
        check($sformatf("mem[%h]", a), mem[a], model[a]);
    endtask

    task automatic check_arch_mem();
        check_mem(A_CRMD); check_mem(A_PRMD); check_mem(A_ESTAT); check_mem(A_ERA);
        check_mem(A_BADV); check_mem(A_EENTRY); check_mem(A_TLBR);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RobCsrValid = 0; ExcValid = 0; ErtnValid = 0;
        RobCsrOp = '0; RobCsrAddr = '0; RobCsrWData = '0; RobCsrMask = '0;
        ExcEcode = '0; ExcEsubcode = '0; ExcPc = '0; ExcBadv = '0; ExcBadvValid = 0;
        #2;
        check_all_zero("reset");
        @(negedge Clk);
        Rest = 1'b1;

        // Rob xchg on SAVE0.
        poke(14'h30, 32'hFFFF0000);
        RobCsrOp = 2'b10; RobCsrAddr = 14'h30; RobCsrWData = 32'h1234ABCD; RobCsrMask = 32'h0000FFFF;
        issue(2, 1);
        check("xchg_result", mem[14'h30], 32'hFFFFABCD);

        // Exception without BADV.
        poke(A_CRMD, 32'h7); poke(A_ESTAT, 32'h0); poke(A_EENTRY, 32'h1C008000);
        ExcEcode = 6'h08; ExcEsubcode = 9'h1; ExcPc = 32'h1C000100; ExcBadvValid = 0;
        issue(0, 1);
        check("exc_prmd", mem[A_PRMD], 32'h7);
        check("exc_crmd", mem[A_CRMD], 32'h0);
        check("exc_era", mem[A_ERA], 32'h1C000100);
        check("exc_estat", mem[A_ESTAT], 32'h00480000);

        // TLB refill exception with BADV.
        poke(A_TLBR, 32'h1C00F000); poke(A_BADV, 32'h0);
        ExcEcode = 6'h3F; ExcEsubcode = 9'h0; ExcPc = 32'h1C000300;
        ExcBadv = 32'hDEAD0000; ExcBadvValid = 1;
        issue(0, 1);
        check("tlbr_badv", mem[A_BADV], 32'hDEAD0000);

        // Ertn.
        poke(A_PRMD, 32'h5); poke(A_CRMD, 32'h8); poke(A_ERA, 32'h1C000200);
        issue(1, 1);
        check("ertn_crmd", mem[A_CRMD], 32'hD);
        check_arch_mem();

        // All three requesters at once: Exc, then Ertn, then Rob.
        poke(14'h31, 32'hA5A5A5A5);
        ExcEcode = 6'h01; ExcEsubcode = 9'h2; ExcPc = 32'h1C000400; ExcBadvValid = 0;
        RobCsrOp = 2'b01; RobCsrAddr = 14'h31; RobCsrWData = 32'h0BADF00D;
        @(negedge Clk);
        ExcValid = 1; ErtnValid = 1; RobCsrValid = 1;
        #1;
        check("prio.first", 32'({ExcReady, ErtnReady, RobCsrReady}), 32'b100);
        prep_exc();
        observe(0, 0, 0);
        @(negedge Clk);
        check("prio.second", 32'({ExcReady, ErtnReady, RobCsrReady}), 32'b010);
        prep_ertn();
        observe(1, 0, 0);
        @(negedge Clk);
        check("prio.third", 32'({ExcReady, ErtnReady, RobCsrReady}), 32'b001);
        prep_rob();
        observe(2, 0, 0);
        check_idle();
        check_arch_mem();
        check_mem(14'h31);

        // Reset in E_ERA: PRMD and CRMD land, nothing after.
        poke(A_CRMD, 32'h3); poke(A_ERA, 32'h11111111); poke(A_ESTAT, 32'h22220000);
        ExcEcode = 6'h04; ExcEsubcode = 9'h0; ExcPc = 32'h1C000500; ExcBadvValid = 1; ExcBadv = 32'h1;
        @(negedge Clk);
        ExcValid = 1;
        #1;
        check("rst.ready", 32'(ExcReady), 32'h1);
        prep_exc();
        observe(0, 0, 3);
        @(negedge Clk);
        check_all_zero("in_reset");
        Rest = 1'b1;
        check_arch_mem();
        check("rst.era_kept", mem[A_ERA], 32'h11111111);
        poke(14'h32, 32'h12345678);
        RobCsrOp = 2'b00; RobCsrAddr = 14'h32;
        issue(2, 1);

        // Randomized requests against the reference model.
        for (int n = 0; n < 24; n++) begin
            int kind;
            logic [13:0] ra;
            kind = int'($urandom_range(0, 2));
            ra = 14'($urandom_range(16, 16383));
            poke(A_CRMD, $urandom); poke(A_PRMD, $urandom); poke(A_ESTAT, $urandom);
            poke(A_ERA, $urandom); poke(A_BADV, $urandom); poke(A_EENTRY, $urandom);
            poke(A_TLBR, $urandom); poke(ra, $urandom);
            scramble();
            RobCsrAddr = ra;
            if ($urandom_range(0, 3) == 0) ExcEcode = 6'h3F;
            issue(kind, 1);
            check_arch_mem();
            check_mem(ra);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
